// File: rtl/tdoa_capture.sv
// Four-microphone onset timestamp capture with TDOA computation relative to mic 0.
// Taus are (t_i - t_0) * TICK_SCALE in units of 2^-25 s, registered on entry to DONE.
module tdoa_capture #(
    parameter int         WINDOW     = 1024,
    parameter logic [9:0] TICK_SCALE = 10'd34
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic [3:0]         mic_hit,
    output logic signed [34:0] tau1,
    output logic signed [34:0] tau2,
    output logic signed [34:0] tau3,
    output logic               valid,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic [2:0] {IDLE, WAIT_FIRST, CAPTURE, CALC, DONE} state_t;

    localparam logic [23:0] WIN = 24'(WINDOW);

    state_t             state_q, state_d;
    logic [23:0]        cnt_q, cnt_d;
    logic [23:0]        ts_q [4];
    logic [23:0]        ts_d [4];
    logic [3:0]         cap_q, cap_d;
    logic signed [34:0] tau_q [3];
    logic signed [34:0] tau_d [3];

    // 25-bit signed difference times the unsigned scale always fits in 35 bits.
    function automatic logic signed [34:0] scaled_delta(input logic [23:0] t, input logic [23:0] t0);
        logic signed [24:0] d;
        d = $signed({1'b0, t}) - $signed({1'b0, t0});
        return 35'(d) * $signed({25'b0, TICK_SCALE});
    endfunction

    always_comb begin
        // NOTE: every signal gets a default up front so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        cap_d   = cap_q;
        tau_d   = tau_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT_FIRST;
                    cap_d   = '0;
                    cnt_d   = '0;
                end
            end
            WAIT_FIRST: begin
                if (|mic_hit) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mic_hit[i]) ts_d[i] = '0;
                    end
                    cap_d   = mic_hit;
                    cnt_d   = 24'd1;
                    state_d = (&mic_hit) ? CALC : CAPTURE;
                end
            end
            CAPTURE: begin
                if (cnt_q == WIN) begin
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (mic_hit[i] && !cap_q[i]) ts_d[i] = cnt_q;
                    end
                    cap_d = cap_q | mic_hit;
                    cnt_d = cnt_q + 24'd1;
                    if (&cap_d) state_d = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < 3; i++) tau_d[i] = scaled_delta(ts_q[i+1], ts_q[0]);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            // NOTE: the timestamp and tau arrays are small register files that must read 0 after reset, so each entry is cleared.
            for (int i = 0; i < 4; i++) ts_q[i] <= '0;
            for (int i = 0; i < 3; i++) tau_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            ts_q    <= ts_d;
            tau_q   <= tau_d;
        end
    end

    assign tau1    = tau_q[0];
    assign tau2    = tau_q[1];
    assign tau3    = tau_q[2];
    assign valid   = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign timeout = (state_q == CAPTURE) && (cnt_q == WIN) && !(&cap_q);

endmodule

// File: tb/tb_tdoa_capture.sv
// Randomized scoreboard bench for tdoa_capture: expected events are queued by the driver
// from first-hit offsets and popped by a monitor whenever valid or timeout appears.
module tb_tdoa_capture;

    localparam int  WINDOW = 1024;
    localparam int  TS     = 34;
    localparam time HALF   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               arm;
    logic [3:0]         mic_hit;
    logic signed [34:0] tau1, tau2, tau3;
    logic               valid, busy, timeout;

    typedef struct {
        bit     is_to;
        int     cyc;
        longint t1, t2, t3;
    } exp_t;

    exp_t   exp_q [$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     fr [4];
    longint cur1 = 0, cur2 = 0, cur3 = 0;

    tdoa_capture #(.WINDOW(WINDOW), .TICK_SCALE(10'd34)) dut (
        .clk(clk), .rst(rst), .arm(arm), .mic_hit(mic_hit),
        .tau1(tau1), .tau2(tau2), .tau3(tau3),
        .valid(valid), .busy(busy), .timeout(timeout)
    );

    always #HALF clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every valid/timeout and checks tau hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            cur1 = 0; cur2 = 0; cur3 = 0;
        end else if (valid || timeout) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {valid, timeout}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind", {valid, timeout}, e.is_to ? 2'b01 : 2'b10);
                check("event_cycle", cyc, e.cyc);
                if (!e.is_to) begin
                    cur1 = e.t1; cur2 = e.t2; cur3 = e.t3;
                end
                check("tau1", tau1, cur1);
                check("tau2", tau2, cur2);
                check("tau3", tau3, cur3);
            end
        end else begin
            check("tau1_hold", tau1, cur1);
            check("tau2_hold", tau2, cur2);
            check("tau3_hold", tau3, cur3);
        end
    end

    task automatic step(input logic a, input logic [3:0] h);
        @(negedge clk);
        arm     = a;
        mic_hit = h;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("event_never_seen", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        check("busy_idle_after", busy, 0);
    endtask

    // Reference: each channel's timestamp is its first-hit offset; complete iff all offsets < WINDOW.
    task automatic run_capture();
        int   last, kend, c0;
        bit   ok;
        exp_t e;
        last = 0;
        ok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (fr[i] < 0 || fr[i] >= WINDOW) ok = 1'b0;
            else if (fr[i] > last) last = fr[i];
        end
        kend = ok ? last : WINDOW;
        step(1'b1, 4'b0);
        repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)), 4'b0);
        for (int k = 0; k <= kend; k++) begin
            logic [3:0] h;
            h = '0;
            for (int i = 0; i < 4; i++)
                if (fr[i] >= 0 && (k == fr[i] || (k > fr[i] && $urandom_range(0, 3) == 0))) h[i] = 1'b1;
            step((k < kend) ? ($urandom_range(0, 7) == 0) : 1'b0, h);
            if (k == 0) begin
                c0      = cyc;
                e.is_to = !ok;
                e.cyc   = ok ? c0 + last + 2 : c0 + WINDOW;
                e.t1    = longint'(fr[1] - fr[0]) * TS;
                e.t2    = longint'(fr[2] - fr[0]) * TS;
                e.t3    = longint'(fr[3] - fr[0]) * TS;
                exp_q.push_back(e);
            end
            check("busy_capture", busy, 1);
        end
        step(1'b0, 4'b0);
        drain();
    endtask

    task automatic set_fr(input int a, input int b, input int c, input int d);
        fr[0] = a; fr[1] = b; fr[2] = c; fr[3] = d;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; mic_hit = '0;
        repeat (3) @(negedge clk);
        check("rst_tau1", tau1, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        step(1'b0, 4'b1111);
        step(1'b0, 4'b0);
        check("no_start_without_arm", busy, 0);

        set_fr(0, 10, 25, 5);           run_capture();
        set_fr(20, 0, 0, 0);            run_capture();
        set_fr(0, 0, 0, 0);             run_capture();
        set_fr(0, 3, 7, -1);            run_capture();
        set_fr(0, 1, 2, WINDOW - 1);    run_capture();
        set_fr(WINDOW, 0, 4, 9);        run_capture();

        // Asynchronous reset in the middle of a capture.
        step(1'b1, 4'b0);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("midrst_tau1", tau1, 0);
        check("midrst_tau2", tau2, 0);
        check("midrst_tau3", tau3, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_timeout", timeout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'($urandom_range(1, 15)));
            check("post_rst_idle", busy, 0);
        end
        step(1'b0, 4'b0);
        set_fr(0, 0, 0, 0);             run_capture();

        for (int n = 0; n < 30; n++) begin
            int z, j, sel;
            for (int i = 0; i < 4; i++) fr[i] = $urandom_range(0, 40);
            z     = $urandom_range(0, 3);
            fr[z] = 0;
            j     = (z + $urandom_range(1, 3)) % 4;
            sel   = $urandom_range(0, 7);
            if (sel == 0) fr[j] = WINDOW - 1 + $urandom_range(0, 1);
            else if (sel == 1) fr[j] = -1;
            run_capture();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
